// File: rtl/irqc_pkg.sv
// irqc_pkg -- shared definitions for the interrupt controller.
//   irqc_state_e : controller FSM states (IDLE, REQ, SERVICE)
//   NUM_SRC_DEF  : default number of interrupt sources
//   VEC_W_DEF    : default vector width (clog2 of NUM_SRC_DEF)
//   prio_encode  : index of the lowest set bit (lowest index = highest priority)
package irqc_pkg;

  localparam int NUM_SRC_DEF = 8;
  localparam int VEC_W_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irqc_state_e;

  // Scans from the top down so the last hit is the lowest set index.
  // An all-zero input returns 0; callers only use the result when
  // the input is known to be non-zero.
  function automatic logic [3:0] prio_encode(input logic [15:0] vec);
    prio_encode = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) prio_encode = 4'(i);
    end
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// irq_edge_detect -- per-source synchronizer and polarity edge detector.
//   clk, rst   : system clock, synchronous active-high reset
//   arm        : high once the history flops hold real samples after reset
//   irq_in     : raw interrupt line, asynchronous to clk
//   edge_sel   : 1 = falling edge triggers, 0 = rising edge triggers
//   edge_pulse : registered one-cycle pulse per detected edge
module irq_edge_detect
  import irqc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic irq_in,
  input  logic edge_sel,
  output logic edge_pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;
  logic edge_q, edge_d;

  // Two-flop synchronizer followed by a one-cycle history flop; the
  // detected edge is registered so pending sets the cycle after detection.
  always_comb begin
    s1_d   = irq_in;
    s2_d   = s1_q;
    prev_d = s2_q;
    edge_d = arm & (edge_sel ? (prev_q & ~s2_q) : (s2_q & ~prev_q));
  end

  // History resets to the inactive level of the selected polarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= edge_sel;
      s2_q   <= edge_sel;
      prev_q <= edge_sel;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
    end
  end

  assign edge_pulse = edge_q;

endmodule

// File: rtl/irq_controller.sv
// irq_controller -- prioritised edge-triggered interrupt controller.
//   clk, rst          : system clock, synchronous active-high reset
//   irq_in, edge_sel  : raw interrupt lines and per-source polarity (1 = falling)
//   mask_wr/mask_data : mask register load strobe and value (1 = enabled)
//   irq_req, irq_vec  : request to CPU and the latched source index
//   irq_ack, eoi      : CPU acknowledge and end-of-interrupt strobes
//   pending           : pending-flag register
// Build option: define IRQC_NESTING_EN to allow a strictly higher-priority
// source to interrupt a handler in SERVICE (nested in-service bitmask).
module irq_controller
  import irqc_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int VEC_W   = VEC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] edge_sel,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_data,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vec,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic [NUM_SRC-1:0] pending
);

  irqc_state_e        state_q, state_d;
  logic               req_q, req_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] insvc_q, insvc_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [1:0]         settle_q, settle_d;

  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] pend_clr;
  logic [NUM_SRC-1:0] vec_onehot;
  logic [VEC_W-1:0]   top_vec;
  logic               arm;

  // Edge detection stays disarmed for three cycles after reset, until
  // the history flops hold real samples. A line already sitting at its
  // active level when reset releases therefore never fakes an edge; an
  // edge arriving inside that window is not recorded.
  assign arm = (settle_q == 2'd3);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_edge_detect u_edge (
      .clk        (clk),
      .rst        (rst),
      .arm        (arm),
      .irq_in     (irq_in[i]),
      .edge_sel   (edge_sel[i]),
      .edge_pulse (edge_det[i])
    );
  end

  assign eligible = pending_q & mask_q;
  assign top_vec  = VEC_W'(prio_encode(16'(eligible)));

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    vec_d      = vec_q;
    insvc_d    = insvc_q;
    pend_clr   = '0;
    vec_onehot = '0;
    vec_onehot[vec_q] = 1'b1;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = REQ;
          req_d   = 1'b1;
          vec_d   = top_vec;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d  = SERVICE;
          req_d    = 1'b0;
          pend_clr = vec_onehot;
          insvc_d  = insvc_q | vec_onehot;
        end else if (mask_wr && !mask_data[vec_q]) begin
          // Withdrawn request; fall back to whatever handler was interrupted.
          req_d   = 1'b0;
          state_d = (|insvc_q) ? SERVICE : IDLE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          // x & (x-1) clears the lowest set bit, i.e. the highest-priority handler.
          insvc_d = insvc_q & (insvc_q - NUM_SRC'(1));
          state_d = (|insvc_d) ? SERVICE : IDLE;
        end
`ifdef IRQC_NESTING_EN
        else if ((|eligible) &&
                 (prio_encode(16'(eligible)) < prio_encode(16'(insvc_q)))) begin
          state_d = REQ;
          req_d   = 1'b1;
          vec_d   = top_vec;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge wins over the acknowledge clear on the same bit.
  always_comb begin
    pending_d = (pending_q & ~pend_clr) | edge_det;
    mask_d    = mask_wr ? mask_data : mask_q;
    settle_d  = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      vec_q     <= '0;
      pending_q <= '0;
      insvc_q   <= '0;
      mask_q    <= '1;
      settle_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      vec_q     <= vec_d;
      pending_q <= pending_d;
      insvc_q   <= insvc_d;
      mask_q    <= mask_d;
      settle_q  <= settle_d;
    end
  end

  assign irq_req = req_q;
  assign irq_vec = vec_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller -- directed self-checking bench for irq_controller
// (NUM_SRC=8). Source 5 is falling-edge triggered, all others rising.
// Nesting expectations follow IRQC_NESTING_EN when it is defined.
module tb_irq_controller;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] edge_sel;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic       irq_req;
  logic [2:0] irq_vec;
  logic       irq_ack;
  logic       eoi;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;

  irq_controller #(.NUM_SRC(8), .VEC_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .edge_sel  (edge_sel),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .irq_req   (irq_req),
    .irq_vec   (irq_vec),
    .irq_ack   (irq_ack),
    .eoi       (eoi),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %0b want 0", irq_req); end
    checks++; if (irq_vec !== 3'd0) begin errors++; $display("[TB] FAIL reset_vec got %0d want 0", irq_vec); end
    checks++; if (pending !== 8'h00) begin errors++; $display("[TB] FAIL reset_pending got %h want 00", pending); end
    rst = 1'b0;
    repeat (6) tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_req got %0b want 0", irq_req); end
    checks++; if (pending !== 8'h00) begin errors++; $display("[TB] FAIL reset_idle_pending got %h want 00", pending); end
  endtask

  task automatic test_falling_edge();
    irq_in[5] = 1'b0;
    tick(); tick(); tick();
    checks++; if (pending !== 8'h00) begin errors++; $display("[TB] FAIL fall_early_pending got %h want 00", pending); end
    tick();
    checks++; if (pending !== 8'h20) begin errors++; $display("[TB] FAIL fall_pending got %h want 20", pending); end
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL fall_req_early got %0b want 0", irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd5) begin errors++; $display("[TB] FAIL fall_req got req=%0b vec=%0d want req=1 vec=5", irq_req, irq_vec); end
    pulse_ack();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h00) begin errors++; $display("[TB] FAIL fall_ack got req=%0b pend=%h want req=0 pend=00", irq_req, pending); end
    irq_in[5] = 1'b1;
    pulse_eoi();
    repeat (5) tick();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h00) begin errors++; $display("[TB] FAIL fall_rise_ignored got req=%0b pend=%h want req=0 pend=00", irq_req, pending); end
  endtask

  task automatic test_priority();
    irq_in = irq_in | 8'h44;
    repeat (4) tick();
    checks++; if (pending !== 8'h44) begin errors++; $display("[TB] FAIL prio_pending got %h want 44", pending); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd2) begin errors++; $display("[TB] FAIL prio_first got req=%0b vec=%0d want req=1 vec=2", irq_req, irq_vec); end
    irq_in = irq_in & ~8'h44;
    pulse_ack();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h40) begin errors++; $display("[TB] FAIL prio_ack got req=%0b pend=%h want req=0 pend=40", irq_req, pending); end
    pulse_eoi();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL prio_eoi_req got %0b want 0", irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd6) begin errors++; $display("[TB] FAIL prio_second got req=%0b vec=%0d want req=1 vec=6", irq_req, irq_vec); end
    pulse_ack();
    pulse_eoi();
    repeat (3) tick();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h00) begin errors++; $display("[TB] FAIL prio_clean got req=%0b pend=%h want req=0 pend=00", irq_req, pending); end
  endtask

  task automatic test_ack_set_collision();
    irq_in[5] = 1'b0;
    repeat (5) tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd5) begin errors++; $display("[TB] FAIL coll_req got req=%0b vec=%0d want req=1 vec=5", irq_req, irq_vec); end
    // Second falling edge timed so its pending set lands on the ack edge.
    irq_in[5] = 1'b1;
    tick(); tick();
    irq_in[5] = 1'b0;
    tick(); tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd5) begin errors++; $display("[TB] FAIL coll_stable got req=%0b vec=%0d want req=1 vec=5", irq_req, irq_vec); end
    pulse_ack();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h20) begin errors++; $display("[TB] FAIL coll_set_wins got req=%0b pend=%h want req=0 pend=20", irq_req, pending); end
    pulse_ack();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h20) begin errors++; $display("[TB] FAIL coll_ack_ignored got req=%0b pend=%h want req=0 pend=20", irq_req, pending); end
    pulse_eoi();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL coll_eoi_req got %0b want 0", irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd5) begin errors++; $display("[TB] FAIL coll_rereq got req=%0b vec=%0d want req=1 vec=5", irq_req, irq_vec); end
    pulse_ack();
    pulse_eoi();
    irq_in[5] = 1'b1;
    repeat (4) tick();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h00) begin errors++; $display("[TB] FAIL coll_clean got req=%0b pend=%h want req=0 pend=00", irq_req, pending); end
  endtask

  task automatic test_mask();
    irq_in[5] = 1'b0;
    repeat (5) tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd5) begin errors++; $display("[TB] FAIL mask_req got req=%0b vec=%0d want req=1 vec=5", irq_req, irq_vec); end
    mask_data = 8'hDF; mask_wr = 1'b1; tick(); mask_wr = 1'b0;
    checks++; if (irq_req !== 1'b0 || pending !== 8'h20) begin errors++; $display("[TB] FAIL mask_drop got req=%0b pend=%h want req=0 pend=20", irq_req, pending); end
    repeat (3) tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL mask_hold got %0b want 0", irq_req); end
    mask_data = 8'hFF; mask_wr = 1'b1; tick(); mask_wr = 1'b0;
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL mask_unmask_delay got %0b want 0", irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd5) begin errors++; $display("[TB] FAIL mask_rereq got req=%0b vec=%0d want req=1 vec=5", irq_req, irq_vec); end
    pulse_ack();
    pulse_eoi();
    irq_in[5] = 1'b1;
    repeat (4) tick();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h00) begin errors++; $display("[TB] FAIL mask_clean got req=%0b pend=%h want req=0 pend=00", irq_req, pending); end
  endtask

  task automatic test_nesting();
    irq_in[5] = 1'b0;
    repeat (5) tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd5) begin errors++; $display("[TB] FAIL nest_req5 got req=%0b vec=%0d want req=1 vec=5", irq_req, irq_vec); end
    pulse_ack();
    irq_in = irq_in | 8'h82;
    repeat (4) tick();
    checks++; if (pending !== 8'h82) begin errors++; $display("[TB] FAIL nest_pending got %h want 82", pending); end
    tick();
`ifdef IRQC_NESTING_EN
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd1) begin errors++; $display("[TB] FAIL nest_preempt got req=%0b vec=%0d want req=1 vec=1", irq_req, irq_vec); end
    pulse_ack();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h80) begin errors++; $display("[TB] FAIL nest_ack1 got req=%0b pend=%h want req=0 pend=80", irq_req, pending); end
    pulse_eoi();
    repeat (3) tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL nest_still_service got %0b want 0", irq_req); end
    pulse_eoi();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL nest_eoi2_req got %0b want 0", irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd7) begin errors++; $display("[TB] FAIL nest_idle_req7 got req=%0b vec=%0d want req=1 vec=7", irq_req, irq_vec); end
    pulse_ack();
    pulse_eoi();
`else
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL nonest_no_req got %0b want 0", irq_req); end
    repeat (3) tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL nonest_hold got %0b want 0", irq_req); end
    pulse_eoi();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL nonest_eoi_req got %0b want 0", irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd1) begin errors++; $display("[TB] FAIL nonest_req1 got req=%0b vec=%0d want req=1 vec=1", irq_req, irq_vec); end
    pulse_ack();
    pulse_eoi();
    tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd7) begin errors++; $display("[TB] FAIL nonest_req7 got req=%0b vec=%0d want req=1 vec=7", irq_req, irq_vec); end
    pulse_ack();
    pulse_eoi();
`endif
    irq_in = 8'h20;
    repeat (4) tick();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h00) begin errors++; $display("[TB] FAIL nest_clean got req=%0b pend=%h want req=0 pend=00", irq_req, pending); end
  endtask

  task automatic test_reset_in_service();
    irq_in[5] = 1'b0;
    repeat (5) tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd5) begin errors++; $display("[TB] FAIL rsv_req got req=%0b vec=%0d want req=1 vec=5", irq_req, irq_vec); end
    pulse_ack();
    irq_in[6] = 1'b1;
    repeat (4) tick();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h40) begin errors++; $display("[TB] FAIL rsv_pending got req=%0b pend=%h want req=0 pend=40", irq_req, pending); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (irq_req !== 1'b0 || pending !== 8'h00 || irq_vec !== 3'd0) begin errors++; $display("[TB] FAIL rsv_reset got req=%0b pend=%h vec=%0d want req=0 pend=00 vec=0", irq_req, pending, irq_vec); end
    // irq_in[5] stays low (falling-edge source) and irq_in[6] stays high.
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (irq_req !== 1'b0 || pending !== 8'h00) begin errors++; $display("[TB] FAIL rsv_no_spurious cycle %0d got req=%0b pend=%h want req=0 pend=00", i, irq_req, pending); end
    end
    irq_in[2] = 1'b1;
    repeat (4) tick();
    checks++; if (pending !== 8'h04) begin errors++; $display("[TB] FAIL rsv_after_pending got %h want 04", pending); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd2) begin errors++; $display("[TB] FAIL rsv_after_req got req=%0b vec=%0d want req=1 vec=2", irq_req, irq_vec); end
    pulse_ack();
    pulse_eoi();
  endtask

  initial begin
    rst       = 1'b1;
    irq_in    = 8'h20;
    edge_sel  = 8'h20;
    mask_wr   = 1'b0;
    mask_data = 8'hFF;
    irq_ack   = 1'b0;
    eoi       = 1'b0;
    test_reset();
    test_falling_edge();
    test_priority();
    test_ack_set_collision();
    test_mask();
    test_nesting();
    test_reset_in_service();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
